// File: rtl/regfile16.sv
// 16 x WIDTH register file: two combinational read ports, one write port and a bulk-clear engine.
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.

module mux16_1 (
    input  logic [15:0] d,
    input  logic [3:0]  sel,
    output logic        y
);
    assign y = d[sel];
endmodule

module regfile16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [3:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic             wr_err
);
    // Handshake: none. wr_en is a one-cycle request accepted only in IDLE;
    // clr_req is sampled in IDLE only; clr_done and wr_err are one-cycle pulses.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    clr_state_t       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             clr_done_nxt;
    logic             wr_err_nxt;
    logic             wr_ok;
    logic [WIDTH-1:0] regs [15];
    logic [WIDTH-1:0] mux_a, mux_b;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_done_nxt = 1'b0;
        wr_err_nxt   = 1'b0;
        wr_ok        = 1'b0;
        case (state)
            IDLE: begin
                wr_ok = wr_en && (wr_addr != 4'd15);
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = 4'd0;
                end
            end
            CLEAR: begin
                wr_err_nxt = wr_en;
                if (cnt == 4'd14) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            clr_done <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            clr_done <= clr_done_nxt;
            wr_err   <= wr_err_nxt;
        end
    end

    // The sweep and an accepted write can never target a register on the same edge:
    // writes are only accepted in IDLE, the sweep only runs in CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (state == CLEAR && cnt == 4'(i))
                    regs[i] <= '0;
                else if (wr_ok && wr_addr == 4'(i))
                    regs[i] <= wr_data;
            end
        end
    end

    assign busy = (state == CLEAR);

    // One 16:1 mux per data bit and port; column 15 is the hardwired-zero register.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [15:0] col;
        for (genvar r = 0; r < 15; r++) begin : g_row
            assign col[r] = regs[r][b];
        end
        assign col[15] = 1'b0;

        mux16_1 u_mux_a (.d(col), .sel(rd_addr_a), .y(mux_a[b]));
        mux16_1 u_mux_b (.d(col), .sel(rd_addr_b), .y(mux_b[b]));
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_data_a = (wr_ok && wr_addr == rd_addr_a) ? wr_data : mux_a;
    assign rd_data_b = (wr_ok && wr_addr == rd_addr_b) ? wr_data : mux_b;
`else
    assign rd_data_a = mux_a;
    assign rd_data_b = mux_b;
`endif

endmodule

// File: tb/tb_regfile16.sv
// Directed plus randomized bench for regfile16 against a behavioural register-file model.

module tb_regfile16;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [3:0]       rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic [3:0]       rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             clr_req;
    logic             busy;
    logic             clr_done;
    logic             wr_err;

    regfile16 #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .wr_err(wr_err)
    );

    // clock/reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // behavioural model: register contents plus clear-sweep position
    logic [WIDTH-1:0] mr [16];
    bit               m_busy;
    int               m_pos;
    bit               m_done;
    bit               m_err;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mr[i] = '0;
        m_busy = 0; m_pos = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit nd, ne;
        nd = 0;
        ne = 0;
        if (!m_busy) begin
            if (wr_en && wr_addr != 4'd15) mr[wr_addr] = wr_data;
            if (clr_req) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end else begin
            ne = wr_en;
            mr[m_pos] = '0;
            if (m_pos == 14) begin
                m_busy = 0;
                nd     = 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        m_done = nd;
        m_err  = ne;
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [3:0] a);
        if (a == 4'd15) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !m_busy && wr_addr != 4'd15 && wr_addr == a) return wr_data;
`endif
        return mr[a];
    endfunction

    // scoreboard comparison
    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rd_a", rd_data_a, exp_rd(rd_addr_a));
        check("rd_b", rd_data_b, exp_rd(rd_addr_b));
        check("busy", {15'd0, busy}, {15'd0, m_busy});
        check("clr_done", {15'd0, clr_done}, {15'd0, m_done});
        check("wr_err", {15'd0, wr_err}, {15'd0, m_err});
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge, checks at +4
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit we, input logic [3:0] wa, input logic [WIDTH-1:0] wd,
                         input logic [3:0] ra, input logic [3:0] rb, input bit cr);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr_a = ra; rd_addr_b = rb; clr_req = cr;
        #3;
        check_all();
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = '0; wr_data = '0; clr_req = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 15; i++) begin
            drive(1, 4'(i), 16'h0100 + 16'(i), 4'(i), 4'd15, 0);
            tick();
        end
        idle_inputs();
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        reset_n = 0;
        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1;
        tick();

        // reset state: every entry reads zero
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 4'(i), 4'(15 - i), 0);
        tick();

        // directed write/readback
        drive(1, 4'd3, 16'hBEEF, 4'd0, 4'd1, 0); tick();
        drive(1, 4'd12, 16'h1234, 4'd3, 4'd12, 0); tick();
        drive(0, 0, 0, 4'd3, 4'd12, 0);
        check("rd3", rd_data_a, 16'hBEEF);
        check("rd12", rd_data_b, 16'h1234);
        tick();
        drive(1, 4'd15, 16'hFFFF, 4'd15, 4'd15, 0); tick();
        drive(0, 0, 0, 4'd15, 4'd3, 0);
        check("rd15", rd_data_a, 16'h0000);
        check("wr15_err", {15'd0, wr_err}, 16'h0000);
        tick();

        // same-cycle read of the register being written
        drive(1, 4'd5, 16'hA5A5, 4'd5, 4'd5, 0);
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", rd_data_a, 16'hA5A5);
`else
        check("nobypass_same", rd_data_a, 16'h0000);
`endif
        tick();
        drive(0, 0, 0, 4'd5, 4'd3, 0);
        check("bypass_after", rd_data_a, 16'hA5A5);
        tick();

        // bulk clear with a write attempted mid-sweep
        fill();
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 22; k++) begin
            if (k == 8)      drive(0, 0, 0, 4'd6, 4'd7, 0);
            else if (k == 4) drive(1, 4'd2, 16'h7777, 4'd2, 4'(k), 0);
            else             drive(0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), k == 0);
            if (k == 8) begin
                check("after7_r6", rd_data_a, 16'h0000);
                check("after7_r7", rd_data_b, 16'h0107);
            end
            if (k == 5) check("wr_err_pulse", {15'd0, wr_err}, 16'h0001);
            busy_cnt += int'(busy);
            done_cnt += int'(clr_done);
            tick();
        end
        check("busy_cycles", 16'(busy_cnt), 16'd15);
        check("done_pulses", 16'(done_cnt), 16'd1);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 4'(i), 4'(i), 0);
        tick();

        // reset during the fourth cycle of a clear
        fill();
        drive(0, 0, 0, 4'd0, 4'd0, 1); tick();
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 4'd10, 4'd14, 0); tick(); end
        drive(0, 0, 0, 4'd10, 4'd14, 0);
        reset_n = 0;
        #1;
        model_reset();
        check("rst_busy", {15'd0, busy}, 16'h0000);
        check("rst_done", {15'd0, clr_done}, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            #0.1;
            check("rst_rd", rd_data_a, 16'h0000);
        end
        @(posedge clk);
        #2 reset_n = 1;
        tick();
        busy_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), k == 0);
            busy_cnt += int'(busy);
            done_cnt += int'(clr_done);
            tick();
        end
        check("rerun_busy", 16'(busy_cnt), 16'd15);
        check("rerun_done", 16'(done_cnt), 16'd1);

        // clr_req held high re-triggers on the done cycle
        fill();
        for (int k = 0; k < 36; k++) begin
            drive(0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
            tick();
        end
        idle_inputs();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 39) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile16.md
Name: regfile16

Overview:
- 16-entry x WIDTH-bit register file with two combinational read ports and one synchronous write port.
- Storage stage directly upstream of the 16:1 read-select muxes. Each read port is built from WIDTH instances of mux16_1, one per data bit, with rd_addr as sel.
- Register 15 is hardwired zero.
- Includes a sequential bulk-clear engine used by the CPU reset/flush sequencer.

Parameters:
- WIDTH, 16, data width of each register and of the read/write data ports.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request this cycle
- wr_addr  input  4  write register index
- wr_data  input  WIDTH  write data
- rd_addr_a  input  4  read port A index
- rd_data_a  output  WIDTH  read port A data, combinational
- rd_addr_b  input  4  read port B index
- rd_data_b  output  WIDTH  read port B data, combinational
- clr_req  input  1  start bulk clear, sampled in IDLE only
- busy  output  1  clear engine active
- clr_done  output  1  one-cycle pulse when the clear completes
- wr_err  output  1  one-cycle registered pulse: a write was dropped

Behaviour:
- Clock and reset: single clock clk. Reset reset_n is asynchronous, active-low.
- Reset (reset_n=0, asynchronous):
  - regs[0..14] = 0.
  - FSM = IDLE, clear counter = 0.
  - busy = 0, clr_done = 0, wr_err = 0.
- Read path:
  - rd_data_x = regs[rd_addr_x], zero-cycle latency, through the per-bit mux16_1 slices.
  - rd_addr_x = 15 always returns 0.
  - Both ports are fully independent; the same address on both ports is legal.
- Write path:
  - On the rising clk edge, if wr_en=1 and FSM=IDLE and wr_addr != 15, then regs[wr_addr] <= wr_data. New data is visible on the reads after that edge.
  - wr_addr=15 with wr_en=1: the write is silently discarded. No wr_err.
  - wr_en=1 while busy=1: the write is discarded and wr_err=1 for the following cycle.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: on a clk edge with clr_req=1. The counter loads 0 and busy goes to 1 from the next cycle.
  - In CLEAR, each edge: regs[cnt] <= 0, then cnt++.
  - At cnt=14, after zeroing regs[14]: FSM -> IDLE, busy -> 0, clr_done=1 for exactly one cycle.
  - Total: 15 cycles with busy=1.
  - clr_req while in CLEAR is ignored; no restart, no queueing.
- Simultaneous events:
  - clr_req=1 and wr_en=1 in the same IDLE cycle: the write is performed on that edge, and the clear starts on the same edge. The written register is zeroed later in the sweep.
  - A clr_req held high continuously re-triggers a new clear on the cycle clr_done is asserted, because FSM=IDLE on that cycle.
- Reads during CLEAR return the current, partially cleared contents: regs below cnt read 0, regs at or above cnt read their old value.
- Reset asserted mid-clear: immediate full reset. busy drops asynchronously and no clr_done is generated.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through forwarding. When a write is accepted this cycle (wr_en=1, IDLE, wr_addr != 15) and rd_addr_x == wr_addr, rd_data_x = wr_data combinationally in the same cycle. Port A and port B are forwarded independently. There is no forwarding for discarded writes.
- Not defined: reads return the pre-write value until the clock edge. No forwarding logic is synthesised.

Test Plan:
- Reset then read: reset_n low, then high; rd_addr_a=0..15 -> rd_data_a=0 for all entries; busy=0, clr_done=0, wr_err=0.
- Write/readback: write regs[3]=16'hBEEF and regs[12]=16'h1234 -> next cycle rd_addr_a=3 gives 16'hBEEF, rd_addr_b=12 gives 16'h1234. Write regs[15]=16'hFFFF -> reads 0, wr_err=0.
- Bypass:
  - Same cycle wr_en=1, wr_addr=5, wr_data=16'hA5A5, rd_addr_a=5.
  - With REGFILE_BYPASS_EN -> rd_data_a=16'hA5A5 in that cycle.
  - Without the macro -> rd_data_a keeps its old value in that cycle and reads 16'hA5A5 after the edge.
- Bulk clear:
  - Fill regs[0..14] with 16'h0100+i, then pulse clr_req.
  - Required: busy=1 for exactly 15 cycles; after 7 CLEAR edges, regs[0..6]=0 and regs[7]=16'h0107; single clr_done pulse; afterwards all reads are 0.
- Write during clear: wr_en=1, wr_addr=2, wr_data=16'h7777 during busy -> wr_err=1 for one cycle; regs[2]=0 after the clear completes.
- Reset mid-clear: reset_n=0 at cycle 4 of CLEAR -> busy=0 immediately, no clr_done, all reads 0. A new clr_req after release runs a full 15-cycle clear.
